// File: rtl/cache_ctrl.sv
// cache_ctrl: lookup controller between a requester, a tag/data cache array
// and a backing memory. One request in flight at a time. A hit answers
// straight from LOOKUP; a miss fetches the line from memory, installs it
// (FILL) and then answers. A fetch that runs out of time answers with
// resp_err instead.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/addr    lookup request; accepted only while req_ready=1
//   req_ready         high only in IDLE
//   cache_addr        latched request address driven to the cache array
//   cache_state       0 = compare, 1 = fill (one cycle per completed fetch)
//   cache_hit         hit indication from the array, sampled in LOOKUP only
//   mem_req/mem_addr  line fetch request, line-aligned address
//   mem_ack           fetch complete, sampled in MEM_WAIT only
//   resp_valid/hit/err response, held until resp_ready
//   hit_count/miss_count wrapping statistics
module cache_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [31:0]      req_addr,
    output logic             req_ready,
    output logic [31:0]      cache_addr,
    output logic             cache_state,
    input  logic             cache_hit,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic             resp_err,
    input  logic             resp_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        MEM_WAIT = 3'd2,
        FILL     = 3'd3,
        RESP     = 3'd4
    } state_t;

    // The counter holds the number of MEM_WAIT cycles already spent; the
    // cycle in which it equals TMO_LAST is the MEM_TIMEOUT-th one.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state;
    logic [31:0] addr_q;
    logic [7:0]  tmo_cnt;

    assign cache_addr = addr_q;
    assign mem_addr   = {addr_q[31:3], 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            tmo_cnt     <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            req_ready   <= 1'b1;
            cache_state <= 1'b0;
            mem_req     <= 1'b0;
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        req_ready <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cache_hit) begin
                        hit_count  <= hit_count + CNT_W'(1);
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b1;
                        resp_err   <= 1'b0;
                        state      <= RESP;
                    end else begin
                        miss_count <= miss_count + CNT_W'(1);
                        tmo_cnt    <= '0;
                        mem_req    <= 1'b1;
                        state      <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    // An ack in the last allowed cycle still completes the fetch.
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        cache_state <= 1'b1;
                        state       <= FILL;
                    end else if (tmo_cnt == TMO_LAST) begin
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_err   <= 1'b1;
                        state      <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                FILL: begin
                    cache_state <= 1'b0;
                    resp_valid  <= 1'b1;
                    resp_hit    <= 1'b0;
                    resp_err    <= 1'b0;
                    state       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_hit   <= 1'b0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    // Unused encodings fall back to a clean IDLE.
                    cache_state <= 1'b0;
                    mem_req     <= 1'b0;
                    resp_valid  <= 1'b0;
                    resp_hit    <= 1'b0;
                    resp_err    <= 1'b0;
                    req_ready   <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl. Each transaction is described by its outcome
// (hit, ack delay, response backpressure); expected outputs per cycle are
// derived from the cycle offset since the accept edge.
module tb_cache_ctrl;
    localparam int T  = 5;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, cache_hit, mem_ack, resp_ready;
    logic [31:0]   req_addr;
    logic          req_ready, cache_state, mem_req, resp_valid, resp_hit, resp_err;
    logic [31:0]   cache_addr, mem_addr;
    logic [CW-1:0] hit_count, miss_count;

    cache_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .cache_addr(cache_addr), .cache_state(cache_state), .cache_hit(cache_hit),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_err(resp_err),
        .resp_ready(resp_ready), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state / expectations for the current cycle
    bit          chk_en = 1'b0;
    int          cur_age = -1;
    int          m_hits = 0, m_miss = 0;
    logic [31:0] m_last = '0;
    logic        exp_ready, exp_mreq, exp_cstate, exp_rv, exp_rhit, exp_rerr;
    logic [31:0] exp_addr, exp_maddr;

    // observations collected by the compare process
    int          meas_lat, n_fill, n_rv;
    bit          seen_rv, cap_err;
    logic [31:0] last_maddr;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (cur_age == 0) begin
                seen_rv = 1'b0; n_fill = 0; n_rv = 0;
            end
            check("req_ready",   32'(req_ready),   32'(exp_ready));
            check("cache_addr",  cache_addr,       exp_addr);
            check("cache_state", 32'(cache_state), 32'(exp_cstate));
            check("mem_req",     32'(mem_req),     32'(exp_mreq));
            if (exp_mreq) check("mem_addr", mem_addr, exp_maddr);
            check("resp_valid",  32'(resp_valid),  32'(exp_rv));
            if (exp_rv) begin
                check("resp_hit", 32'(resp_hit), 32'(exp_rhit));
                check("resp_err", 32'(resp_err), 32'(exp_rerr));
            end
            check("hit_count",  32'(hit_count),  32'(m_hits));
            check("miss_count", 32'(miss_count), 32'(m_miss));
            if (resp_valid && !seen_rv) begin
                seen_rv = 1'b1; meas_lat = cur_age; cap_err = resp_err;
            end
            if (resp_valid)  n_rv++;
            if (cache_state) n_fill++;
            if (mem_req)     last_maddr = mem_addr;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk_en = 1'b1; cur_age = -1;
            exp_ready = 1'b1; exp_addr = m_last; exp_mreq = 1'b0;
            exp_cstate = 1'b0; exp_rv = 1'b0;
            req_valid = 1'b0; req_addr = $urandom;
            cache_hit = 1'($urandom); mem_ack = 1'($urandom); resp_ready = 1'($urandom);
            cyc();
        end
    endtask

    // One request from accept to response handshake. ack_dly = MEM_WAIT
    // cycle (1-based) in which mem_ack is raised; beyond T it never comes.
    task automatic run_txn(input logic [31:0] addr, input bit hit,
                           input int ack_dly, input int rdy_wait);
        bit acked = !hit && (ack_dly <= T);
        int w     = acked ? ack_dly : T;
        int r     = hit ? 2 : (acked ? w + 3 : w + 2);
        bit done  = 1'b0;
        chk_en = 1'b1;
        for (int age = 0; !done; age++) begin
            cur_age = age;
            if (age == 1) m_last = addr;
            if (age == 2) begin
                if (hit) m_hits = (m_hits + 1) % (1 << CW);
                else     m_miss = (m_miss + 1) % (1 << CW);
            end
            exp_ready  = (age == 0);
            exp_addr   = m_last;
            exp_mreq   = !hit && age >= 2 && age <= w + 1;
            exp_maddr  = {addr[31:3], 3'b000};
            exp_cstate = acked && age == w + 2;
            exp_rv     = age >= r;
            exp_rhit   = hit;
            exp_rerr   = !hit && !acked;

            req_valid = 1'b1;
            req_addr  = (age == 0) ? addr : $urandom;
            cache_hit = (age == 1) ? hit : 1'($urandom);
            mem_ack   = exp_mreq ? (age - 1 == ack_dly) : 1'($urandom);
            resp_ready = (age >= r) ? (age - r >= rdy_wait) : 1'($urandom);
            done = (age >= r) && resp_ready;
            cyc();
        end
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; cache_hit = 1'b0; mem_ack = 1'b0; resp_ready = 1'b0;
        cyc(); cyc();
        check("rst_req_ready",  32'(req_ready),   32'd1);
        check("rst_cache_addr", cache_addr,       32'd0);
        check("rst_cache_st",   32'(cache_state), 32'd0);
        check("rst_mem_req",    32'(mem_req),     32'd0);
        check("rst_resp_valid", 32'(resp_valid),  32'd0);
        check("rst_resp_hit",   32'(resp_hit),    32'd0);
        check("rst_resp_err",   32'(resp_err),    32'd0);
        check("rst_hit_cnt",    32'(hit_count),   32'd0);
        check("rst_miss_cnt",   32'(miss_count),  32'd0);
        rst = 1'b0;
        m_hits = 0; m_miss = 0; m_last = '0;
        idle(1);
    endtask

    initial begin
        do_reset();

        // hit: response two cycles after accept
        run_txn(32'h0000_0048, 1'b1, 0, 0);
        check("hit_latency", 32'(meas_lat), 32'd2);
        check("hit_count_1", 32'(hit_count), 32'd1);
        idle(1);

        // miss acked in the 4th MEM_WAIT cycle
        run_txn(32'h1234_5677, 1'b0, 4, 0);
        check("miss_latency", 32'(meas_lat), 32'd7);
        check("miss_maddr",   last_maddr, 32'h1234_5670);
        check("miss_fills",   32'(n_fill), 32'd1);
        check("miss_count_1", 32'(miss_count), 32'd1);

        // timeout: no ack at all
        run_txn(32'h0000_1000, 1'b0, 99, 0);
        check("tmo_latency", 32'(meas_lat), 32'(T + 2));
        check("tmo_err",     32'(cap_err), 32'd1);
        check("tmo_fills",   32'(n_fill), 32'd0);

        // ack in the same cycle the timeout expires: ack wins
        run_txn(32'h0000_2004, 1'b0, T, 1);
        check("coin_latency", 32'(meas_lat), 32'(T + 3));
        check("coin_err",     32'(cap_err), 32'd0);
        check("coin_fills",   32'(n_fill), 32'd1);

        // backpressure: 5 cycles without resp_ready, req_valid held high
        run_txn(32'hCAFE_0010, 1'b1, 0, 5);
        check("bp_resp_cycles", 32'(n_rv), 32'd6);

        // counter wrap at CNT_W=2
        do_reset();
        for (int i = 0; i < 5; i++) run_txn(32'h100 + 32'(i * 8), 1'b1, 0, 0);
        check("wrap_hit_count", 32'(hit_count), 32'd1);

        // reset in MEM_WAIT, then a stray ack
        do_reset();
        chk_en = 1'b0;
        req_valid = 1'b1; req_addr = 32'hABCD_EF01; cyc();
        req_valid = 1'b0; cache_hit = 1'b0; mem_ack = 1'b0; cyc();
        cyc(); cyc();
        check("mw_pre_mem_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mw_rst_mem_req",   32'(mem_req),    32'd0);
        check("mw_rst_req_ready", 32'(req_ready),  32'd1);
        check("mw_rst_miss_cnt",  32'(miss_count), 32'd0);
        check("mw_rst_cache_addr", cache_addr,     32'd0);
        cyc();
        rst = 1'b0; mem_ack = 1'b1; resp_ready = 1'b1; cyc();
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("late_ack_resp", 32'(resp_valid), 32'd0);
            check("late_ack_ready", 32'(req_ready), 32'd1);
            check("late_ack_cstate", 32'(cache_state), 32'd0);
            cyc();
        end
        m_hits = 0; m_miss = 0; m_last = '0;
        idle(1);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            run_txn($urandom, 1'($urandom), int'($urandom_range(1, T + 2)),
                    int'($urandom_range(0, 3)));
            idle(int'($urandom_range(0, 2)));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
